mcp_rx_port: RTL and testbench



---
 rtl/mcp_pkg.sv | 12 +
 rtl/mcp_rx_fifo.sv | 73 +++++++
 rtl/sync2.sv | 27 ++
 rtl/mcp_rx_port.sv | 104 ++++++++++
 tb/tb_mcp_rx_port.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mcp_pkg.sv
// Shared defaults and helpers for the MCP receive endpoint.
package mcp_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int DEPTH_DEF  = 2;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mcp_rx_fifo.sv
// Small receive FIFO: unreset storage, wrapping pointers, occupancy and a
// registered not-empty flag. Callers must not write when full or read when
// empty; the endpoint gates its strobes accordingly.
module mcp_rx_fifo
    import mcp_pkg::*;
#(
    parameter  int DWIDTH = DWIDTH_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int AW     = $clog2(DEPTH),
    localparam int LW     = level_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic [LW-1:0]     level,
    output logic              not_empty
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [LW-1:0] LVL_ZERO = LW'(0);

    logic [DWIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic [LW-1:0]     level_nxt_s;
    logic              valid_r;

    // Next occupancy: a simultaneous write and read cancel out.
    always_comb begin
        level_nxt_s = level_r;
        case ({wr_en, rd_en})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointers, occupancy and not-empty flag; pointers wrap as DEPTH is 2^AW.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_nxt_s;
            valid_r <= (level_nxt_s != LVL_ZERO);
        end
    end

    // Data storage is deliberately left unreset; valid_r guards its use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data   = mem_r[rd_ptr_r];
    assign level     = level_r;
    assign not_empty = valid_r;

endmodule

// File: rtl/sync2.sv
// Two-flop synchronizer for slow level signals crossing into clk.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability-settling chain, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/mcp_rx_port.sv
// Receive endpoint of the toggle-based MCP handshake: synchronizes the
// request toggle, captures the held bus into a FIFO, returns the ack toggle
// once the word is stored and flags requests that arrive before their ack.
module mcp_rx_port
    import mcp_pkg::*;
#(
    parameter  int DWIDTH = DWIDTH_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int LW     = level_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_tgl,
    input  logic [DWIDTH-1:0] req_data,
    output logic              ack_tgl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [LW-1:0]     level,
    output logic              proto_err
);

    localparam logic [LW-1:0] LVL_DEPTH = LW'(DEPTH);

    logic          req_s2_s;
    logic          req_s3_r;
    logic          req_evt_s;
    logic          pend_r;
    logic          pend_nxt_s;
    logic          cap_s;
    logic          pop_s;
    logic          ack_r;
    logic          err_r;
    logic [LW-1:0] level_s;
    logic          valid_s;

    sync2 #(
        .WIDTH (1)
    ) u_req_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (req_tgl),
        .q    (req_s2_s)
    );

    mcp_rx_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en     (cap_s),
        .wr_data   (req_data),
        .rd_en     (pop_s),
        .rd_data   (out_data),
        .level     (level_s),
        .not_empty (valid_s)
    );

    // One pulse per synchronized toggle of the request level.
    assign req_evt_s = req_s2_s ^ req_s3_r;

    // Capture decision uses the registered level, so a pop from full only
    // frees the slot for the following cycle.
    assign cap_s = pend_r & (level_s < LVL_DEPTH);
    assign pop_s = valid_s & out_ready;

    // Pending request: a new event wins over a simultaneous capture.
    always_comb begin
        pend_nxt_s = pend_r;
        if (req_evt_s) begin
            pend_nxt_s = 1'b1;
        end else if (cap_s) begin
            pend_nxt_s = 1'b0;
        end else begin
            pend_nxt_s = pend_r;
        end
    end

    // Edge-detect delay, pending flag, ack toggle and sticky error flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_s3_r <= 1'b0;
            pend_r   <= 1'b0;
            ack_r    <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            req_s3_r <= req_s2_s;
            pend_r   <= pend_nxt_s;
            if (cap_s) begin
                ack_r <= ~ack_r;
            end
            if (req_evt_s && pend_r) begin
                err_r <= 1'b1;
            end
        end
    end

    assign ack_tgl   = ack_r;
    assign proto_err = err_r;
    assign out_valid = valid_s;
    assign level     = level_s;

endmodule

// File: tb/tb_mcp_rx_port.sv
module tb_mcp_rx_port;

    localparam int DW = 8;
    localparam int DP = 2;
    localparam int LW = $clog2(DP) + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_tgl = 1'b0;
    logic [DW-1:0] req_data = '0;
    logic          ack_tgl;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [LW-1:0] level;
    logic          proto_err;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    int            ready_mode = 0;   // 0: driven by scenario, 1: random, 2: one cycle after valid
    logic          valid_seen = 1'b0;
    bit            track_max = 1'b0;
    int            max_lvl = 0;

    mcp_rx_port #(.DWIDTH(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_tgl   (req_tgl),
        .req_data  (req_data),
        .ack_tgl   (ack_tgl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sender model: toggle with data held, record expectation, wait for ack.
    task automatic send(input logic [DW-1:0] d, input int bound, input bit want_ack,
                        input string name, output int lat);
        @(posedge clk);
        #1;
        req_data = d;
        req_tgl  = ~req_tgl;
        exp_q.push_back(d);
        lat = 0;
        for (int i = 1; i <= bound; i++) begin
            @(posedge clk);
            #1;
            if (ack_tgl === req_tgl) begin
                lat = i;
                break;
            end
        end
        if (want_ack) check({name, "_ack"}, ack_tgl, req_tgl);
    endtask

    task automatic drain(input string name);
        ready_mode = 0;
        out_ready  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            cycles(1);
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_level0"}, level, 0);
        out_ready = 1'b0;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset(input logic req_level, input string name);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check({name, "_valid"}, out_valid, 0);
        check({name, "_level"}, level, 0);
        check({name, "_ack"}, ack_tgl, 0);
        check({name, "_err"}, proto_err, 0);
        exp_q.delete();
        req_tgl   = req_level;
        out_ready = 1'b0;
        cycles(3);
        #2;
        rstn = 1'b1;
    endtask

    // Consumer side: drives out_ready in the autonomous modes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
            else if (ready_mode == 2) out_ready = valid_seen;
        end
    end

    // Monitor: pop the scoreboard on every accepted output word.
    initial begin
        forever begin
            @(negedge clk);
            valid_seen = out_valid;
            if (rstn) begin
                check("valid_vs_level", out_valid, (level != 0));
                check("level_bound", (level <= DP), 1);
                if (track_max && int'(level) > max_lvl) max_lvl = int'(level);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", out_data, 32'hFFFF_FFFF);
                    end else begin
                        check("out_data", out_data, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [DW-1:0] rd;

        cycles(2);
        check("rst_ack", ack_tgl, 0);
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_err", proto_err, 0);
        #2;
        rstn = 1'b1;
        cycles(3);
        check("idle_no_capture", level, 0);

        // Single transfer with latency check.
        send(8'hA5, 20, 1'b1, "single", lat);
        check("single_latency", (lat >= 4 && lat <= 5), 1);
        check("single_level", level, 1);
        cycles(1);
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 8'hA5);
        drain("single");

        // Backpressure: third word waits for a free slot.
        out_ready = 1'b0;
        send(8'h11, 20, 1'b1, "bp1", lat);
        send(8'h22, 20, 1'b1, "bp2", lat);
        send(8'h33, 10, 1'b0, "bp3", lat);
        check("bp_full_level", level, 2);
        check("bp_ack_withheld", (ack_tgl !== req_tgl), 1);
        out_ready = 1'b1;
        cycles(1);
        out_ready = 1'b0;
        check("bp_after_pop_level", level, 1);
        check("bp_after_pop_ack", (ack_tgl !== req_tgl), 1);
        cycles(1);
        check("bp_capture_level", level, 2);
        check("bp_capture_ack", ack_tgl, req_tgl);
        drain("bp");

        // Streaming with a consumer that is always ready.
        ready_mode = 0;
        out_ready  = 1'b1;
        max_lvl    = 0;
        track_max  = 1'b1;
        for (int i = 0; i < 8; i++) send(8'(i), 20, 1'b1, "stream", lat);
        drain("stream");
        track_max = 1'b0;
        check("stream_max_level", (max_lvl <= 1), 1);
        check("stream_err", proto_err, 0);

        // Random data and gaps against a randomly stalling consumer.
        ready_mode = 1;
        for (int i = 0; i < 30; i++) begin
            rd = 8'($urandom);
            send(rd, 300, 1'b1, "rand", lat);
            cycles($urandom_range(0, 3));
        end
        drain("rand");

        // Wrap-around: consumer pops one cycle after valid rises.
        ready_mode = 2;
        for (int i = 0; i < 5; i++) send(8'hF0 + 8'(i), 40, 1'b1, "wrap", lat);
        drain("wrap");
        check("wrap_err", proto_err, 0);

        // Protocol violation: two toggles one clock apart while full.
        out_ready = 1'b0;
        send(8'h41, 20, 1'b1, "pv1", lat);
        send(8'h42, 20, 1'b1, "pv2", lat);
        @(posedge clk);
        #1;
        req_tgl = ~req_tgl;
        @(posedge clk);
        #1;
        req_tgl = ~req_tgl;
        cycles(8);
        check("proto_err_set", proto_err, 1);
        cycles(20);
        check("proto_err_sticky", proto_err, 1);
        check("pv_level_full", level, 2);

        // Reset mid-operation (full, request pending), release with req_tgl=0.
        do_reset(1'b0, "rst_mid");
        cycles(10);
        check("rst_mid_no_capture", level, 0);
        check("rst_mid_ack", ack_tgl, 0);
        check("rst_mid_err", proto_err, 0);

        // Release with req_tgl=1 produces exactly one spurious capture.
        do_reset(1'b1, "rst_hi");
        cycles(12);
        check("spurious_level", level, 1);
        check("spurious_ack", ack_tgl, 1);
        do_reset(1'b0, "rst_end");
        cycles(5);
        check("end_level", level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
